console_action_sequencer: RTL and testbench
===========================================

// Module: console_action_sequencer
// PURPOSE
//  Executes decoded escape/print commands from the parser against the cursor and text RAM.
//  Holds cursor_x/cursor_y. Applies movement commands with clamping.
//  Walks multi-cell erase ranges (ED/EL) one cell per granted RAM cycle.
//  Shares the text-RAM write port with the display path through a request/grant pair.
// PARAMETERS
//  COLS   80     screen columns, 2..255
//  ROWS   24     screen rows, 2..255
//  BLANK  8'h20  character written by erase operations
// PORTS
//  clk        in   1  clock
//  rst        in   1  reset, asynchronous, active-low
//  cmd_valid  in   1  command present from parser
//  cmd_ready  out  1  sequencer accepts command this cycle
//  cmd_type   in   4  cmd_t: NOP,PRINT,CUP,CUU,CUD,CUF,CUB,ED,EL; other codes are NOP
//  pn1        in   8  first numeric parameter
//  pn2        in   8  second numeric parameter
//  ch         in   8  character for PRINT
//  ram_we     out  1  write request to text RAM
//  ram_gnt    in   1  write performed this cycle when ram_we&&ram_gnt
//  ram_row    out  8  write row
//  ram_col    out  8  write column
//  ram_data   out  8  write data
//  cursor_x   out  8  cursor column, 0..COLS-1
//  cursor_y   out  8  cursor row, 0..ROWS-1
//  busy       out  1  state != IDLE
// BEHAVIOUR
//  Reset: state IDLE, cursor 0/0, ram_we=0, row/col/data=0, cmd_ready=1. Reset mid-erase abandons it.
//  Handshake: command accepted iff cmd_valid&&cmd_ready. cmd_ready=1 only in IDLE.
//  cmd_ready, ram_we and the ram_* outputs are registered and never depend combinationally on ram_gnt.
//  Parameter default: for CUx/CUP, pn==0 is treated as 1. ED/EL use pn1 raw as the mode.
//  CUP: cursor_y=min(pn1',ROWS)-1 and cursor_x=min(pn2',COLS)-1, where pn' is the defaulted pn.
//  CUU/CUD/CUF/CUB: move by pn1' with saturation at 0 and at ROWS-1/COLS-1. No wrap.
//  Cursor commands: the cursor updates on the edge that accepts the command (one-cycle latency).
//  Cursor commands keep the state in IDLE.
//  PRINT: go to PUT and drive ram_we=1 with row/col=cursor and data=ch. Hold until the grant.
//   Edge with ram_gnt: ram_we falls and the FSM returns to IDLE.
//   On that same edge the cursor advances: x+1. If x==COLS-1, then x=0 and y=min(y+1,ROWS-1).
//   No scroll.
//  ED pn1: 0 = cursor..(ROWS-1,COLS-1); 1 = (0,0)..cursor; 2 = whole screen.
//  EL pn1: 0 = cursor..end of line; 1 = line start..cursor; 2 = whole line.
//  Other ED/EL modes are NOP.
//  Erase ranges are inclusive and row-major.
//  ERASE state: drive ram_we=1 with data=BLANK at the walker position.
//   Each granted cycle advances the walker.
//   The grant on the last cell returns the FSM to IDLE.
//   The cursor is not changed by erase.
//  Cycle counts: erase of N cells = N granted cycles, with ram_gnt stalls allowed.
//   Full-screen erase = ROWS*COLS grants.
//  ram_gnt while ram_we=0 is ignored.
//  cmd_valid during PUT/ERASE is ignored (not accepted), and the parser holds it.
// STRUCTURE
//  console_pkg: cmd_t enum (4-bit), ED/EL mode constants, default COLS/ROWS/BLANK.
//  Sub-module erase_range_walker: load(start_row,start_col,end_row,end_col), step on grant,
//   outputs row/col/last. Cursor clamp arithmetic lives in a package function.
//  Sequencer: 3-state FSM (IDLE, PUT, ERASE), cursor registers, RAM request registers.
// TESTING
//  Reset then CUP pn1=5 pn2=10 -> cursor_y=4, cursor_x=9 on the next edge; cmd_ready stays 1.
//  CUP pn1=0 pn2=200 (COLS=80) -> cursor 0/79. Then CUF pn1=5 -> x stays 79. CUB pn1=0 -> x=78.
//  Cursor (79,3), PRINT 'A', ram_gnt held low 3 cycles then high ->
//   ram_we=1 for 4 cycles with row 3, col 79, data 8'h41; cursor becomes (0,4).
//  Cursor (5,2), EL pn1=0, gnt=1 -> 75 writes of 8'h20 at row 2, cols 5..79.
//   cmd_ready=0 throughout; cursor unchanged.
//  ED pn1=2 with random gnt -> every cell (0,0)..(23,79) written exactly once, in row-major order.
//  Reset asserted mid-ED -> ram_we=0 and cursor 0/0 immediately.
//   After release, a new CUP is accepted on the first cycle.

Source files
------------

// File: rtl/console_action_sequencer_pkg.sv
// Shared types, defaults and cursor arithmetic for the console action sequencer.
package console_action_sequencer_pkg;

  localparam int unsigned DEF_COLS  = 80;
  localparam int unsigned DEF_ROWS  = 24;
  localparam logic [7:0]  DEF_BLANK = 8'h20;

  typedef enum logic [3:0] {
    CMD_NOP   = 4'd0,
    CMD_PRINT = 4'd1,
    CMD_CUP   = 4'd2,
    CMD_CUU   = 4'd3,
    CMD_CUD   = 4'd4,
    CMD_CUF   = 4'd5,
    CMD_CUB   = 4'd6,
    CMD_ED    = 4'd7,
    CMD_EL    = 4'd8
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PUT   = 2'd1,
    ST_ERASE = 2'd2
  } state_t;

  // ED/EL mode selectors carried in pn1
  localparam logic [7:0] MODE_TO_END     = 8'd0;
  localparam logic [7:0] MODE_FROM_START = 8'd1;
  localparam logic [7:0] MODE_ALL        = 8'd2;

  function automatic logic [7:0] pn_default(input logic [7:0] pn);
    return (pn == 8'd0) ? 8'd1 : pn;
  endfunction

  function automatic logic [7:0] clamp_add(input logic [7:0] pos, input logic [7:0] delta,
                                           input logic [7:0] max);
    logic [8:0] sum;
    sum = {1'b0, pos} + {1'b0, delta};
    return (sum > {1'b0, max}) ? max : sum[7:0];
  endfunction

  function automatic logic [7:0] clamp_sub(input logic [7:0] pos, input logic [7:0] delta);
    return (delta > pos) ? 8'd0 : pos - delta;
  endfunction

  // Absolute 1-based position to 0-based, clamped to the screen extent
  function automatic logic [7:0] cup_pos(input logic [7:0] pn, input logic [7:0] limit);
    logic [7:0] p;
    p = pn_default(pn);
    return ((p > limit) ? limit : p) - 8'd1;
  endfunction

endpackage

// File: rtl/console_action_sequencer_erase_range_walker.sv
// Row-major walker over an inclusive (row,col) range; advances one cell per step.
module erase_range_walker
  import console_action_sequencer_pkg::*;
#(
  parameter int unsigned COLS = DEF_COLS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] start_row_i,
  input  logic [7:0] start_col_i,
  input  logic [7:0] end_row_i,
  input  logic [7:0] end_col_i,
  input  logic       step_i,
  output logic [7:0] row_o,
  output logic [7:0] col_o,
  output logic       last_o
);

  localparam logic [7:0] COL_MAX = 8'(COLS - 1);

  logic [7:0] row_q, col_q, end_row_q, end_col_q;
  logic [7:0] row_d, col_d;
  logic       last_q;

  always_comb begin
    row_d = row_q;
    col_d = col_q + 8'd1;
    if (col_q == COL_MAX) begin
      col_d = 8'd0;
      row_d = row_q + 8'd1;
    end
  end

  // Position stays on the final cell once reached so the outputs remain stable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q     <= 8'd0;
      col_q     <= 8'd0;
      end_row_q <= 8'd0;
      end_col_q <= 8'd0;
      last_q    <= 1'b0;
    end else if (load_i) begin
      row_q     <= start_row_i;
      col_q     <= start_col_i;
      end_row_q <= end_row_i;
      end_col_q <= end_col_i;
      last_q    <= (start_row_i == end_row_i) && (start_col_i == end_col_i);
    end else if (step_i && !last_q) begin
      row_q  <= row_d;
      col_q  <= col_d;
      last_q <= (row_d == end_row_q) && (col_d == end_col_q);
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = last_q;

endmodule

// File: rtl/console_action_sequencer.sv
// Executes parsed PRINT/cursor/erase commands against the cursor and the shared text-RAM write port.
module console_action_sequencer
  import console_action_sequencer_pkg::*;
#(
  parameter int unsigned COLS  = DEF_COLS,
  parameter int unsigned ROWS  = DEF_ROWS,
  parameter logic [7:0]  BLANK = DEF_BLANK
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_type,
  input  logic [7:0] pn1,
  input  logic [7:0] pn2,
  input  logic [7:0] ch,
  output logic       ram_we,
  input  logic       ram_gnt,
  output logic [7:0] ram_row,
  output logic [7:0] ram_col,
  output logic [7:0] ram_data,
  output logic [7:0] cursor_x,
  output logic [7:0] cursor_y,
  output logic       busy
);

  localparam logic [7:0] COLS_W  = 8'(COLS);
  localparam logic [7:0] ROWS_W  = 8'(ROWS);
  localparam logic [7:0] COL_MAX = 8'(COLS - 1);
  localparam logic [7:0] ROW_MAX = 8'(ROWS - 1);

  state_t     state_q;
  logic [7:0] cursor_x_q, cursor_y_q, ram_data_q;
  logic       ram_we_q, cmd_ready_q, busy_q;

  logic [7:0] start_row_d, start_col_d, end_row_d, end_col_d;
  logic       erase_ok_d;
  logic       accept_c, load_c, step_c, walk_last;

  assign accept_c = cmd_valid && cmd_ready_q;
  assign step_c   = ram_we_q && ram_gnt;

  // Range selection; PRINT reuses the defaults as a single-cell range at the cursor
  always_comb begin
    start_row_d = cursor_y_q;
    start_col_d = cursor_x_q;
    end_row_d   = cursor_y_q;
    end_col_d   = cursor_x_q;
    erase_ok_d  = 1'b0;
    case (cmd_type)
      CMD_ED: begin
        case (pn1)
          MODE_TO_END: begin
            erase_ok_d = 1'b1;
            end_row_d  = ROW_MAX;
            end_col_d  = COL_MAX;
          end
          MODE_FROM_START: begin
            erase_ok_d  = 1'b1;
            start_row_d = 8'd0;
            start_col_d = 8'd0;
          end
          MODE_ALL: begin
            erase_ok_d  = 1'b1;
            start_row_d = 8'd0;
            start_col_d = 8'd0;
            end_row_d   = ROW_MAX;
            end_col_d   = COL_MAX;
          end
          default: ;
        endcase
      end
      CMD_EL: begin
        case (pn1)
          MODE_TO_END: begin
            erase_ok_d = 1'b1;
            end_col_d  = COL_MAX;
          end
          MODE_FROM_START: begin
            erase_ok_d  = 1'b1;
            start_col_d = 8'd0;
          end
          MODE_ALL: begin
            erase_ok_d  = 1'b1;
            start_col_d = 8'd0;
            end_col_d   = COL_MAX;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign load_c = accept_c && ((cmd_type == CMD_PRINT) || erase_ok_d);

  erase_range_walker #(.COLS(COLS)) u_walker (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load_c),
    .start_row_i(start_row_d),
    .start_col_i(start_col_d),
    .end_row_i  (end_row_d),
    .end_col_i  (end_col_d),
    .step_i     (step_c),
    .row_o      (ram_row),
    .col_o      (ram_col),
    .last_o     (walk_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cursor_x_q  <= 8'd0;
      cursor_y_q  <= 8'd0;
      ram_we_q    <= 1'b0;
      ram_data_q  <= 8'd0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            case (cmd_type)
              CMD_PRINT: begin
                state_q     <= ST_PUT;
                ram_we_q    <= 1'b1;
                ram_data_q  <= ch;
                cmd_ready_q <= 1'b0;
                busy_q      <= 1'b1;
              end
              CMD_CUP: begin
                cursor_y_q <= cup_pos(pn1, ROWS_W);
                cursor_x_q <= cup_pos(pn2, COLS_W);
              end
              CMD_CUU: cursor_y_q <= clamp_sub(cursor_y_q, pn_default(pn1));
              CMD_CUD: cursor_y_q <= clamp_add(cursor_y_q, pn_default(pn1), ROW_MAX);
              CMD_CUF: cursor_x_q <= clamp_add(cursor_x_q, pn_default(pn1), COL_MAX);
              CMD_CUB: cursor_x_q <= clamp_sub(cursor_x_q, pn_default(pn1));
              CMD_ED, CMD_EL: begin
                if (erase_ok_d) begin
                  state_q     <= ST_ERASE;
                  ram_we_q    <= 1'b1;
                  ram_data_q  <= BLANK;
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        ST_PUT: begin
          if (step_c) begin
            state_q     <= ST_IDLE;
            ram_we_q    <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            if (cursor_x_q == COL_MAX) begin
              cursor_x_q <= 8'd0;
              cursor_y_q <= (cursor_y_q == ROW_MAX) ? cursor_y_q : cursor_y_q + 8'd1;
            end else begin
              cursor_x_q <= cursor_x_q + 8'd1;
            end
          end
        end
        ST_ERASE: begin
          if (step_c && walk_last) begin
            state_q     <= ST_IDLE;
            ram_we_q    <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign ram_we    = ram_we_q;
  assign ram_data  = ram_data_q;
  assign cursor_x  = cursor_x_q;
  assign cursor_y  = cursor_y_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_console_action_sequencer.sv
// Directed bench for console_action_sequencer at the default 80x24 geometry.
module tb_console_action_sequencer;
  import console_action_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, ram_we, ram_gnt, busy;
  logic [3:0] cmd_type;
  logic [7:0] pn1, pn2, ch, ram_row, ram_col, ram_data, cursor_x, cursor_y;

  int n_cmp  = 0;
  int n_fail = 0;

  console_action_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_type (cmd_type),
    .pn1      (pn1),
    .pn2      (pn2),
    .ch       (ch),
    .ram_we   (ram_we),
    .ram_gnt  (ram_gnt),
    .ram_row  (ram_row),
    .ram_col  (ram_col),
    .ram_data (ram_data),
    .cursor_x (cursor_x),
    .cursor_y (cursor_y),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Present one command for a single edge, return 1 time unit after that edge
  task automatic issue(input cmd_t t, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c);
    cmd_type  = t;
    pn1       = a;
    pn2       = b;
    ch        = c;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Drive grants until ram_we drops; tally writes and mismatches against a row-major walk
  task automatic drain_erase(input bit rnd, input int budget, input logic [7:0] sr,
                             input logic [7:0] sc, output int nw, output int nbad,
                             output bit rdy_seen, output bit timed_out);
    logic [7:0] er, ec;
    logic       g;
    int         cyc;
    nw = 0; nbad = 0; rdy_seen = 0; timed_out = 0; er = sr; ec = sc; cyc = 0;
    while (ram_we === 1'b1 && !timed_out) begin
      g = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      ram_gnt = g;
      if (cmd_ready !== 1'b0) rdy_seen = 1;
      if (g) begin
        if (ram_row !== er || ram_col !== ec || ram_data !== 8'h20) nbad++;
        nw++;
        if (ec == 8'd79) begin ec = 8'd0; er = er + 8'd1; end
        else ec = ec + 8'd1;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (cyc > budget) timed_out = 1;
    end
    ram_gnt = 1'b0;
  endtask

  task automatic test_reset;
    n_cmp++; if (cursor_x !== 8'd0 || cursor_y !== 8'd0) begin n_fail++;
      $display("FAIL reset_cursor: got x=%0d y=%0d want 0/0", cursor_x, cursor_y); end
    n_cmp++; if (ram_we !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_ctrl: got we=%b busy=%b rdy=%b want 0 0 1", ram_we, busy, cmd_ready); end
    n_cmp++; if (ram_row !== 8'd0 || ram_col !== 8'd0 || ram_data !== 8'd0) begin n_fail++;
      $display("FAIL reset_ram: got %0d/%0d/%h want 0/0/00", ram_row, ram_col, ram_data); end
  endtask

  task automatic test_cup;
    issue(CMD_CUP, 8'd5, 8'd10, 8'd0);
    n_cmp++; if (cursor_y !== 8'd4 || cursor_x !== 8'd9) begin n_fail++;
      $display("FAIL cup_5_10: got x=%0d y=%0d want 9/4", cursor_x, cursor_y); end
    n_cmp++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin n_fail++;
      $display("FAIL cup_ready: got rdy=%b busy=%b want 1 0", cmd_ready, busy); end
  endtask

  task automatic test_clamp;
    issue(CMD_CUP, 8'd0, 8'd200, 8'd0);
    n_cmp++; if (cursor_y !== 8'd0 || cursor_x !== 8'd79) begin n_fail++;
      $display("FAIL cup_clamp: got x=%0d y=%0d want 79/0", cursor_x, cursor_y); end
    issue(CMD_CUF, 8'd5, 8'd0, 8'd0);
    n_cmp++; if (cursor_x !== 8'd79) begin n_fail++;
      $display("FAIL cuf_sat: got x=%0d want 79", cursor_x); end
    issue(CMD_CUB, 8'd0, 8'd0, 8'd0);
    n_cmp++; if (cursor_x !== 8'd78) begin n_fail++;
      $display("FAIL cub_default: got x=%0d want 78", cursor_x); end
    issue(CMD_CUD, 8'd100, 8'd0, 8'd0);
    n_cmp++; if (cursor_y !== 8'd23) begin n_fail++;
      $display("FAIL cud_sat: got y=%0d want 23", cursor_y); end
    issue(CMD_CUU, 8'd0, 8'd0, 8'd0);
    n_cmp++; if (cursor_y !== 8'd22) begin n_fail++;
      $display("FAIL cuu_default: got y=%0d want 22", cursor_y); end
    issue(CMD_CUU, 8'd250, 8'd0, 8'd0);
    n_cmp++; if (cursor_y !== 8'd0) begin n_fail++;
      $display("FAIL cuu_sat: got y=%0d want 0", cursor_y); end
    issue(CMD_CUB, 8'd3, 8'd0, 8'd0);
    n_cmp++; if (cursor_x !== 8'd75) begin n_fail++;
      $display("FAIL cub_3: got x=%0d want 75", cursor_x); end
  endtask

  task automatic test_print;
    int wcyc;
    issue(CMD_CUP, 8'd4, 8'd80, 8'd0);
    ram_gnt = 1'b0;
    issue(CMD_PRINT, 8'd0, 8'd0, 8'h41);
    wcyc = 0;
    for (int k = 0; k < 4; k++) begin
      if (ram_we === 1'b1 && ram_row === 8'd3 && ram_col === 8'd79 && ram_data === 8'h41
          && cmd_ready === 1'b0 && busy === 1'b1) wcyc++;
      ram_gnt = (k == 3);
      @(posedge clk);
      #1;
    end
    ram_gnt = 1'b0;
    n_cmp++; if (wcyc !== 4) begin n_fail++;
      $display("FAIL print_stall: got %0d good request cycles want 4", wcyc); end
    n_cmp++; if (ram_we !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++;
      $display("FAIL print_done: got we=%b rdy=%b want 0 1", ram_we, cmd_ready); end
    n_cmp++; if (cursor_x !== 8'd0 || cursor_y !== 8'd4) begin n_fail++;
      $display("FAIL print_wrap: got x=%0d y=%0d want 0/4", cursor_x, cursor_y); end
  endtask

  task automatic test_print_corner;
    issue(CMD_CUP, 8'd24, 8'd80, 8'd0);
    ram_gnt = 1'b1;
    issue(CMD_PRINT, 8'd0, 8'd0, 8'h5A);
    n_cmp++; if (ram_we !== 1'b1 || ram_row !== 8'd23 || ram_col !== 8'd79 || ram_data !== 8'h5A)
      begin n_fail++;
      $display("FAIL print_corner_req: got we=%b %0d/%0d/%h want 1 23/79/5a",
               ram_we, ram_row, ram_col, ram_data); end
    @(posedge clk);
    #1;
    ram_gnt = 1'b0;
    n_cmp++; if (cursor_x !== 8'd0 || cursor_y !== 8'd23 || ram_we !== 1'b0) begin n_fail++;
      $display("FAIL print_noscroll: got x=%0d y=%0d we=%b want 0/23 0", cursor_x, cursor_y, ram_we); end
  endtask

  task automatic test_el;
    int nw, nbad; bit rdy, to;
    issue(CMD_CUP, 8'd3, 8'd6, 8'd0);
    issue(CMD_EL, 8'd0, 8'd0, 8'd0);
    drain_erase(1'b0, 200, 8'd2, 8'd5, nw, nbad, rdy, to);
    n_cmp++; if (nw !== 75 || to) begin n_fail++;
      $display("FAIL el0_count: got %0d writes timeout=%b want 75", nw, to); end
    n_cmp++; if (nbad !== 0) begin n_fail++;
      $display("FAIL el0_order: got %0d bad cells want 0", nbad); end
    n_cmp++; if (rdy !== 1'b0 || cursor_x !== 8'd5 || cursor_y !== 8'd2) begin n_fail++;
      $display("FAIL el0_side: got rdy_seen=%b x=%0d y=%0d want 0 5/2", rdy, cursor_x, cursor_y); end
  endtask

  task automatic test_ed_modes;
    int nw, nbad; bit rdy, to;
    issue(CMD_CUP, 8'd2, 8'd3, 8'd0);
    issue(CMD_ED, 8'd1, 8'd0, 8'd0);
    drain_erase(1'b0, 300, 8'd0, 8'd0, nw, nbad, rdy, to);
    n_cmp++; if (nw !== 83 || nbad !== 0 || to) begin n_fail++;
      $display("FAIL ed1: got %0d writes %0d bad want 83 0", nw, nbad); end
    issue(CMD_ED, 8'd3, 8'd0, 8'd0);
    n_cmp++; if (ram_we !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++;
      $display("FAIL ed3_nop: got we=%b busy=%b rdy=%b want 0 0 1", ram_we, busy, cmd_ready); end
    issue(CMD_CUP, 8'd24, 8'd78, 8'd0);
    issue(CMD_ED, 8'd0, 8'd0, 8'd0);
    drain_erase(1'b1, 100, 8'd23, 8'd77, nw, nbad, rdy, to);
    n_cmp++; if (nw !== 3 || nbad !== 0 || to) begin n_fail++;
      $display("FAIL ed0_tail: got %0d writes %0d bad want 3 0", nw, nbad); end
  endtask

  task automatic test_ed_full;
    int nw, nbad; bit rdy, to;
    issue(CMD_CUP, 8'd7, 8'd7, 8'd0);
    issue(CMD_ED, 8'd2, 8'd0, 8'd0);
    drain_erase(1'b1, 20000, 8'd0, 8'd0, nw, nbad, rdy, to);
    n_cmp++; if (nw !== 1920 || to) begin n_fail++;
      $display("FAIL ed2_count: got %0d writes timeout=%b want 1920", nw, to); end
    n_cmp++; if (nbad !== 0) begin n_fail++;
      $display("FAIL ed2_order: got %0d bad cells want 0", nbad); end
    n_cmp++; if (rdy !== 1'b0 || cursor_x !== 8'd6 || cursor_y !== 8'd6) begin n_fail++;
      $display("FAIL ed2_side: got rdy_seen=%b x=%0d y=%0d want 0 6/6", rdy, cursor_x, cursor_y); end
  endtask

  task automatic test_reset_mid_erase;
    issue(CMD_CUP, 8'd3, 8'd6, 8'd0);
    issue(CMD_ED, 8'd2, 8'd0, 8'd0);
    ram_gnt = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    n_cmp++; if (ram_we !== 1'b1 || busy !== 1'b1) begin n_fail++;
      $display("FAIL mid_erase_active: got we=%b busy=%b want 1 1", ram_we, busy); end
    rst = 1'b0;
    #1;
    n_cmp++; if (ram_we !== 1'b0 || cursor_x !== 8'd0 || cursor_y !== 8'd0) begin n_fail++;
      $display("FAIL async_reset: got we=%b x=%0d y=%0d want 0 0/0", ram_we, cursor_x, cursor_y); end
    ram_gnt = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cmd_type = CMD_CUP; pn1 = 8'd5; pn2 = 8'd10; cmd_valid = 1'b1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++;
      $display("FAIL post_reset_ready: got %b want 1", cmd_ready); end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    n_cmp++; if (cursor_x !== 8'd9 || cursor_y !== 8'd4 || busy !== 1'b0) begin n_fail++;
      $display("FAIL post_reset_cup: got x=%0d y=%0d busy=%b want 9/4 0", cursor_x, cursor_y, busy); end
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_type = 4'd0; pn1 = 8'd0; pn2 = 8'd0; ch = 8'd0;
    ram_gnt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    rst = 1'b1;
    @(posedge clk);
    #1;
    test_reset;
    test_cup;
    test_clamp;
    test_print;
    test_print_corner;
    test_el;
    test_ed_modes;
    test_ed_full;
    test_reset_mid_erase;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
